// File: rtl/gs_fwd_ctrl_if.sv
// Decode-side bus between the ID stage and the forwarding/hazard controller.
// Valid/ready note: there is no ready; `stall` is the back-channel that holds the ID entry in place.
interface gs_fwd_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int SEL_WIDTH  = 2
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_rd_we;
    logic                  id_is_load;
    logic                  pipe_hold;
    logic                  flush;
    logic                  stall;
    logic [SEL_WIDTH-1:0]  fwd_sel_a;
    logic [SEL_WIDTH-1:0]  fwd_sel_b;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output id_rd, id_rd_we, id_is_load, pipe_hold, flush,
        input  stall, fwd_sel_a, fwd_sel_b
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  id_rd, id_rd_we, id_is_load, pipe_hold, flush,
        output stall, fwd_sel_a, fwd_sel_b
    );
endinterface

// File: rtl/gs_fwd_ctrl.sv
// Operand-forwarding and load-use stall controller tracking the EX and MEM producer slots.
// Optional stall performance counter enabled by defining GS_FWD_PERF_EN.
module gs_fwd_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int SEL_WIDTH  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    gs_fwd_ctrl_if.slave  bus
`ifdef GS_FWD_PERF_EN
    ,
    output logic [15:0]   perf_stall_cnt
`endif
);
    localparam logic [SEL_WIDTH-1:0] SEL_RF  = '0;
    localparam logic [SEL_WIDTH-1:0] SEL_EX  = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0] SEL_MEM = SEL_WIDTH'(2);

    logic                  ex_valid_q, ex_we_q, ex_load_q;
    logic [REG_ADDR_W-1:0] ex_rd_q;
    logic                  mem_valid_q, mem_we_q, mem_load_q;
    logic [REG_ADDR_W-1:0] mem_rd_q;
    logic [SEL_WIDTH-1:0]  sel_a_q, sel_b_q;

    logic                  ex_prod, mem_prod;
    logic                  a_need, b_need;
    logic                  a_ex, b_ex, a_mem, b_mem;
    logic                  stall_c;
    logic                  ex_valid_d;
    logic [SEL_WIDTH-1:0]  sel_a_c, sel_b_c;
    logic [SEL_WIDTH-1:0]  sel_a_d, sel_b_d;

    always_comb begin
        ex_prod  = ex_valid_q & ex_we_q & (ex_rd_q != '0);
        mem_prod = mem_valid_q & mem_we_q & (mem_rd_q != '0);
        a_need   = bus.id_rs1_used & (bus.id_rs1 != '0);
        b_need   = bus.id_rs2_used & (bus.id_rs2 != '0);
        a_ex     = a_need & ex_prod  & (ex_rd_q  == bus.id_rs1);
        b_ex     = b_need & ex_prod  & (ex_rd_q  == bus.id_rs2);
        a_mem    = a_need & mem_prod & (mem_rd_q == bus.id_rs1);
        b_mem    = b_need & mem_prod & (mem_rd_q == bus.id_rs2);

        // A load in EX has no result yet; the consumer waits one edge and then sees it in MEM.
        stall_c  = bus.id_valid & ex_load_q & (a_ex | b_ex);

        sel_a_c  = a_ex ? SEL_EX : (a_mem ? SEL_MEM : SEL_RF);
        sel_b_c  = b_ex ? SEL_EX : (b_mem ? SEL_MEM : SEL_RF);

        ex_valid_d = bus.id_valid & ~stall_c & ~bus.flush;
        sel_a_d    = ex_valid_d ? sel_a_c : SEL_RF;
        sel_b_d    = ex_valid_d ? sel_b_c : SEL_RF;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_we_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            ex_rd_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_load_q  <= 1'b0;
            mem_rd_q    <= '0;
            sel_a_q     <= SEL_RF;
            sel_b_q     <= SEL_RF;
        end else if (!bus.pipe_hold) begin
            mem_valid_q <= ex_valid_q;
            mem_we_q    <= ex_we_q;
            mem_load_q  <= ex_load_q;
            mem_rd_q    <= ex_rd_q;
            ex_valid_q  <= ex_valid_d;
            ex_we_q     <= bus.id_rd_we;
            ex_load_q   <= bus.id_is_load;
            ex_rd_q     <= bus.id_rd;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
        end else if (bus.flush) begin
            // Flush kills the EX entry even while held; MEM stays frozen.
            ex_valid_q  <= 1'b0;
            sel_a_q     <= SEL_RF;
            sel_b_q     <= SEL_RF;
        end
    end

    assign bus.stall     = stall_c;
    assign bus.fwd_sel_a = sel_a_q;
    assign bus.fwd_sel_b = sel_b_q;

`ifdef GS_FWD_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (stall_c && !bus.pipe_hold && perf_q != 16'hFFFF) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`endif
endmodule

// File: tb/tb_gs_fwd_ctrl.sv
// Directed bench for gs_fwd_ctrl: stall checked in the ID cycle, selects queued and checked in EX.
module tb_gs_fwd_ctrl;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    logic [3:0] exp_q[$];

    gs_fwd_ctrl_if #(.REG_ADDR_W(5), .SEL_WIDTH(2)) bus ();

`ifdef GS_FWD_PERF_EN
    logic [15:0] perf_stall_cnt;
    gs_fwd_ctrl #(.REG_ADDR_W(5), .SEL_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .perf_stall_cnt(perf_stall_cnt)
    );
`else
    gs_fwd_ctrl #(.REG_ADDR_W(5), .SEL_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
`endif

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        bus.id_valid    = 1'b0;
        bus.id_rs1      = '0;
        bus.id_rs2      = '0;
        bus.id_rs1_used = 1'b0;
        bus.id_rs2_used = 1'b0;
        bus.id_rd       = '0;
        bus.id_rd_we    = 1'b0;
        bus.id_is_load  = 1'b0;
        bus.pipe_hold   = 1'b0;
        bus.flush       = 1'b0;
    endtask

    // driver: one ID cycle; called at a negedge, returns at the next negedge
    task automatic step(input string tag,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic we, input logic ld,
                        input logic hold, input logic fl,
                        input logic es, input logic [1:0] ea, input logic [1:0] eb);
        logic [3:0] got;
        bus.id_valid    = 1'b1;
        bus.id_rs1      = rs1;
        bus.id_rs1_used = u1;
        bus.id_rs2      = rs2;
        bus.id_rs2_used = u2;
        bus.id_rd       = rd;
        bus.id_rd_we    = we;
        bus.id_is_load  = ld;
        bus.pipe_hold   = hold;
        bus.flush       = fl;
        #1;
        chk({tag, ".stall"}, 16'(bus.stall), 16'(es));
        exp_q.push_back({ea, eb});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue_empty"}, 16'd0, 16'd1);
        end else begin
            got = exp_q.pop_front();
            chk({tag, ".sel_a"}, 16'(bus.fwd_sel_a), 16'(got[3:2]));
            chk({tag, ".sel_b"}, 16'(bus.fwd_sel_b), 16'(got[1:0]));
        end
        @(negedge clk);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.stall", 16'(bus.stall), 16'd0);
        chk("rst.sel_a", 16'(bus.fwd_sel_a), 16'd0);
        chk("rst.sel_b", 16'(bus.fwd_sel_b), 16'd0);
        rst_n = 1'b1;

        // EX forward: add x5, then consumer of x5 on rs1
        step("t1.prod", 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t1.cons", 5'd5, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);

        // MEM forward: x6, independent, consumer of x6 on rs2
        step("t2.prod", 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t2.indp", 5'd1, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t2.cons", 5'd2, 1'b1, 5'd6, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);

        // Load-use: load x7, consumer of x7 stalls once, then gets MEM forward
        step("t3.load", 5'd8, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t3.stl",  5'd1, 1'b1, 5'd7, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        step("t3.cons", 5'd1, 1'b1, 5'd7, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
`ifdef GS_FWD_PERF_EN
        chk("t3.perf", perf_stall_cnt, 16'd1);
`endif

        // x0 never forwards or stalls; unused sources never match
        step("t4.ld0",  5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t4.rd0",  5'd0, 1'b1, 5'd0, 1'b1, 5'd20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t4.ld14", 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t4.unus", 5'd14, 1'b0, 5'd14, 1'b0, 5'd21, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

        // Both slots write x3: younger (EX) wins on both sources
        step("t5.p1",   5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t5.p2",   5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t5.cons", 5'd3, 1'b1, 5'd3, 1'b1, 5'd22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01);

        // Hold freezes selects; flush during hold clears EX but MEM stays frozen
        step("t6.p20",  5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t6.p21",  5'd0, 1'b0, 5'd0, 1'b0, 5'd21, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t6.cons", 5'd21, 1'b1, 5'd20, 1'b1, 5'd23, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10);
        step("t6.hold", 5'd23, 1'b1, 5'd0, 1'b0, 5'd24, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10);
        step("t6.hfl",  5'd23, 1'b1, 5'd0, 1'b0, 5'd24, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        step("t6.aft",  5'd21, 1'b1, 5'd23, 1'b1, 5'd25, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);

        // Reset during a load-use stall drops the hazard
        step("t7.load", 5'd0, 1'b0, 5'd0, 1'b0, 5'd15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        bus.id_rs1      = 5'd15;
        bus.id_rs1_used = 1'b1;
        bus.id_rs2_used = 1'b0;
        bus.id_rd       = 5'd26;
        bus.id_is_load  = 1'b0;
        #1;
        chk("t7.stall_pre", 16'(bus.stall), 16'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t7.stall_post", 16'(bus.stall), 16'd0);
        chk("t7.sel_a", 16'(bus.fwd_sel_a), 16'd0);
        chk("t7.sel_b", 16'(bus.fwd_sel_b), 16'd0);
`ifdef GS_FWD_PERF_EN
        chk("t7.perf", perf_stall_cnt, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step("t7.cons", 5'd15, 1'b1, 5'd0, 1'b0, 5'd26, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

        chk("final.queue", 16'(exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
